// File: rtl/aes_key_expander_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_key_expander_if                                                      |
// | Key-load and round-key read bus. Optional read_inv: AES_KEY_EQ_INV_EN.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface aes_key_expander_if #(
    parameter int MAX_KEY_BITS = 256,
    parameter int RD_ADDR_W    = 4
);
    logic                    start;
    logic [1:0]              key_len;
    logic [MAX_KEY_BITS-1:0] original_key;
    logic [RD_ADDR_W-1:0]    read_addr;
`ifdef AES_KEY_EQ_INV_EN
    logic                    read_inv;
`endif
    logic [127:0]            round_key;
    logic [3:0]              num_rounds;
    logic                    busy;
    logic                    generation_done;

    modport master (
        output start, key_len, original_key, read_addr,
`ifdef AES_KEY_EQ_INV_EN
        output read_inv,
`endif
        input  round_key, num_rounds, busy, generation_done
    );

    modport slave (
        input  start, key_len, original_key, read_addr,
`ifdef AES_KEY_EQ_INV_EN
        input  read_inv,
`endif
        output round_key, num_rounds, busy, generation_done
    );
endinterface
`default_nettype wire

// File: rtl/aes_key_expander.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_key_expander                                                         |
// | AES-128/192/256 key schedule, one word per clock, registered round-key   |
// | reads. Macro AES_KEY_EQ_INV_EN adds InvMixColumns (equivalent inverse).  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module aes_key_expander #(
    parameter int MAX_KEY_BITS = 256,
    parameter int RD_ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    aes_key_expander_if.slave bus
);
    localparam int c_MAX_NK = MAX_KEY_BITS / 32;
    localparam int c_MAX_NR = c_MAX_NK + 6;
    localparam int c_DEPTH  = 4 * (c_MAX_NR + 1);
    localparam int c_IDX_W  = $clog2(c_DEPTH);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_LOAD   = 2'd1;
    localparam logic [1:0] c_S_EXPAND = 2'd2;
    localparam logic [1:0] c_S_DONE   = 2'd3;

    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return c_SBOX[2047 - 8*int'(a) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] gf_x2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

`ifdef AES_KEY_EQ_INV_EN
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        for (int k = 0; k < 4; k++) begin
            a[k]   = c[31-8*k -: 8];
            x2[k]  = gf_x2(a[k]);
            x4[k]  = gf_x2(x2[k]);
            x8[k]  = gf_x2(x4[k]);
            m9[k]  = x8[k] ^ a[k];
            m11[k] = x8[k] ^ x2[k] ^ a[k];
            m13[k] = x8[k] ^ x4[k] ^ a[k];
            m14[k] = x8[k] ^ x4[k] ^ x2[k];
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction
`endif

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic                    w_busy;
    logic                    w_done;
    logic [MAX_KEY_BITS-1:0] r_key;
    logic [3:0]              r_nk;
    logic [3:0]              r_nr;
    logic [c_IDX_W-1:0]      r_i;
    logic [2:0]              r_mod;
    logic [7:0]              r_rcon;
    logic [31:0]             r_store [c_DEPTH];
    logic [127:0]            r_round_key;
    logic [3:0]              w_nk_sel;
    logic                    w_start_ok;
    logic [c_IDX_W-1:0]      w_last_idx;
    logic [31:0]             w_prev;
    logic [31:0]             w_back;
    logic                    w_rot_phase;
    logic                    w_sub_phase;
    logic [31:0]             w_sub_out;
    logic [31:0]             w_temp;
    logic [c_IDX_W-1:0]      w_rd_base;
    logic                    w_rd_valid;
    logic [127:0]            w_rd_word;
    logic [127:0]            w_rd_data;

    // 2'b11 falls through to the 128-bit schedule
    always_comb begin
        w_nk_sel = 4'd4;
        case (bus.key_len)
            2'b01:   w_nk_sel = 4'd6;
            2'b10:   w_nk_sel = 4'd8;
            default: w_nk_sel = 4'd4;
        endcase
        if (w_nk_sel > 4'(c_MAX_NK)) w_nk_sel = 4'(c_MAX_NK);
    end

    assign w_start_ok = bus.start && ((r_state == c_S_IDLE) || (r_state == c_S_DONE));
    assign w_last_idx = c_IDX_W'({r_nr, 2'b11});

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:   if (w_start_ok) w_next_state = c_S_LOAD;
            c_S_LOAD:   w_next_state = c_S_EXPAND;
            c_S_EXPAND: if (r_i == w_last_idx) w_next_state = c_S_DONE;
            c_S_DONE:   if (w_start_ok) w_next_state = c_S_LOAD;
            default:    w_next_state = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == c_S_LOAD) || (r_state == c_S_EXPAND);
        w_done = (r_state == c_S_DONE);
    end

    // r_mod tracks i mod Nk so no divider is needed
    assign w_prev      = r_store[r_i - c_IDX_W'(1)];
    assign w_back      = r_store[r_i - c_IDX_W'(r_nk)];
    assign w_rot_phase = (r_mod == 3'd0);
    assign w_sub_phase = (r_nk == 4'd8) && (r_mod == 3'd4);
    assign w_sub_out   = sub_word(w_rot_phase ? {w_prev[23:0], w_prev[31:24]} : w_prev);
    assign w_temp      = w_rot_phase ? (w_sub_out ^ {r_rcon, 24'h0}) :
                         w_sub_phase ? w_sub_out : w_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key  <= '0;
            r_nk   <= 4'd4;
            r_nr   <= 4'd10;
            r_i    <= '0;
            r_mod  <= 3'd0;
            r_rcon <= 8'h01;
        end else begin
            if (w_start_ok) begin
                r_key <= bus.original_key;
                r_nk  <= w_nk_sel;
                r_nr  <= w_nk_sel + 4'd6;
            end
            if (r_state == c_S_LOAD) begin
                r_i    <= c_IDX_W'(r_nk);
                r_mod  <= 3'd0;
                r_rcon <= 8'h01;
            end else if (r_state == c_S_EXPAND) begin
                r_i   <= r_i + c_IDX_W'(1);
                r_mod <= ({1'b0, r_mod} == (r_nk - 4'd1)) ? 3'd0 : (r_mod + 3'd1);
                if (w_rot_phase) r_rcon <= gf_x2(r_rcon);
            end
        end
    end

    // Word store is deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (r_state == c_S_LOAD) begin
            for (int j = 0; j < c_MAX_NK; j++) begin
                if (j < int'(r_nk)) r_store[j] <= r_key[MAX_KEY_BITS-1-32*j -: 32];
            end
        end else if (r_state == c_S_EXPAND) begin
            r_store[r_i] <= w_back ^ w_temp;
        end
    end

    assign w_rd_base  = c_IDX_W'({bus.read_addr, 2'b00});
    assign w_rd_valid = int'(bus.read_addr) <= int'(r_nr);
    assign w_rd_word  = {r_store[w_rd_base], r_store[w_rd_base + c_IDX_W'(1)],
                         r_store[w_rd_base + c_IDX_W'(2)], r_store[w_rd_base + c_IDX_W'(3)]};

`ifdef AES_KEY_EQ_INV_EN
    // First and last round keys stay untransformed in the equivalent inverse cipher
    always_comb begin
        w_rd_data = w_rd_word;
        if (bus.read_inv && (bus.read_addr != '0) && (int'(bus.read_addr) < int'(r_nr)))
            w_rd_data = {inv_mix_col(w_rd_word[127:96]), inv_mix_col(w_rd_word[95:64]),
                         inv_mix_col(w_rd_word[63:32]),  inv_mix_col(w_rd_word[31:0])};
    end
`else
    assign w_rd_data = w_rd_word;
`endif

    always_ff @(posedge clk) begin
        if (rst)         r_round_key <= '0;
        else if (w_done) r_round_key <= w_rd_valid ? w_rd_data : 128'h0;
    end

    assign bus.round_key       = r_round_key;
    assign bus.num_rounds      = r_nr;
    assign bus.busy            = w_busy;
    assign bus.generation_done = w_done;
endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_aes_key_expander                                                      |
// | Directed FIPS-197 vectors for aes_key_expander. Rev 1.0                  |
// +--------------------------------------------------------------------------+
module tb_aes_key_expander;
    localparam logic [127:0] c_K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] c_K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] c_K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] c_R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] c_R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_key_expander_if #(.MAX_KEY_BITS(256), .RD_ADDR_W(4)) bus ();
    aes_key_expander #(.MAX_KEY_BITS(256), .RD_ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [1:0] len, input logic [255:0] key);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.key_len      = len;
        bus.original_key = key;
        @(negedge clk);
        bus.start = 1'b0;
        check("done_low_after_start", 128'(bus.generation_done), 128'd0);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.generation_done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic read_key(input int addr, output logic [127:0] rk);
        @(negedge clk);
        bus.read_addr = 4'(addr);
`ifdef AES_KEY_EQ_INV_EN
        bus.read_inv = 1'b0;
`endif
        @(negedge clk);
        rk = bus.round_key;
    endtask

`ifdef AES_KEY_EQ_INV_EN
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model_inv_mix(input logic [127:0] rk);
        logic [127:0] r;
        logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(coef[(k - row + 4) % 4], rk[127 - 32*c - 8*k -: 8]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        return r;
    endfunction

    task automatic read_key_inv(input int addr, output logic [127:0] rk);
        @(negedge clk);
        bus.read_addr = 4'(addr);
        bus.read_inv  = 1'b1;
        @(negedge clk);
        rk = bus.round_key;
        bus.read_inv = 1'b0;
    endtask
`endif

    initial begin
        int           lat;
        logic [127:0] rk;
        logic         saw_done;
        bus.start        = 1'b0;
        bus.key_len      = 2'b00;
        bus.original_key = '0;
        bus.read_addr    = '0;
`ifdef AES_KEY_EQ_INV_EN
        bus.read_inv     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_busy", 128'(bus.busy), 128'd0);
        check("reset_done", 128'(bus.generation_done), 128'd0);
        check("reset_num_rounds", 128'(bus.num_rounds), 128'd10);
        check("reset_round_key", bus.round_key, 128'd0);
        rst = 1'b0;
        read_key(1, rk);
        check("read_before_done_holds", rk, 128'd0);

        // 128-bit key; LSB junk must be ignored
        pulse_start(2'b00, {c_K128, 128'hdeadbeefcafef00d0123456789abcdef});
        check("k128_busy", 128'(bus.busy), 128'd1);
        wait_done(lat);
        check("k128_latency", 128'(lat), 128'd41);
        check("k128_busy_after", 128'(bus.busy), 128'd0);
        check("k128_num_rounds", 128'(bus.num_rounds), 128'd10);
        read_key(0, rk);  check("k128_round0", rk, c_K128);
        read_key(1, rk);  check("k128_round1", rk, c_R128_1);
        read_key(10, rk); check("k128_round10", rk, c_R128_10);
        read_key(11, rk); check("k128_round11_zero", rk, 128'd0);
        read_key(15, rk); check("k128_round15_zero", rk, 128'd0);

        pulse_start(2'b11, {c_K128, 128'h0});
        wait_done(lat);
        check("klen11_latency", 128'(lat), 128'd41);
        check("klen11_num_rounds", 128'(bus.num_rounds), 128'd10);
        read_key(10, rk); check("klen11_round10", rk, c_R128_10);

        pulse_start(2'b01, {c_K192, 64'hffffffffffffffff});
        wait_done(lat);
        check("k192_latency", 128'(lat), 128'd47);
        check("k192_num_rounds", 128'(bus.num_rounds), 128'd12);
        read_key(12, rk); check("k192_round12", rk, c_R192_12);
        read_key(13, rk); check("k192_round13_zero", rk, 128'd0);

        pulse_start(2'b10, c_K256);
        wait_done(lat);
        check("k256_latency", 128'(lat), 128'd53);
        check("k256_num_rounds", 128'(bus.num_rounds), 128'd14);
        read_key(1, rk);  check("k256_round1", rk, c_K256[127:0]);
        read_key(14, rk); check("k256_round14", rk, c_R256_14);

        // A 256-bit start arriving mid-expansion must be ignored
        pulse_start(2'b00, {c_K128, 128'h0});
        lat = 0;
        while (bus.generation_done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 19) begin
                bus.start        = 1'b1;
                bus.key_len      = 2'b10;
                bus.original_key = c_K256;
            end else if (lat == 20) begin
                bus.start = 1'b0;
            end
        end
        check("busy_start_latency", 128'(lat), 128'd41);
        check("busy_start_num_rounds", 128'(bus.num_rounds), 128'd10);
        read_key(10, rk); check("busy_start_round10", rk, c_R128_10);

        // Reset in the middle of a 192-bit expansion
        pulse_start(2'b01, {c_K192, 64'h0});
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 14) rst = 1'b1;
        end
        check("midrst_done", 128'(bus.generation_done), 128'd0);
        check("midrst_busy", 128'(bus.busy), 128'd0);
        check("midrst_num_rounds", 128'(bus.num_rounds), 128'd10);
        check("midrst_round_key", bus.round_key, 128'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.generation_done === 1'b1) saw_done = 1'b1;
        end
        check("midrst_never_done", 128'(saw_done), 128'd0);
        pulse_start(2'b10, c_K256);
        wait_done(lat);
        check("postrst_latency", 128'(lat), 128'd53);
        read_key(14, rk); check("postrst_round14", rk, c_R256_14);

`ifdef AES_KEY_EQ_INV_EN
        pulse_start(2'b00, {c_K128, 128'h0});
        wait_done(lat);
        read_key_inv(0, rk);  check("inv_round0", rk, c_K128);
        read_key_inv(1, rk);  check("inv_round1", rk, model_inv_mix(c_R128_1));
        read_key_inv(10, rk); check("inv_round10", rk, c_R128_10);
        read_key(1, rk);      check("inv_off_round1", rk, c_R128_1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Parametrised successor to the AES-128-only round-key generator.
- Expands a 128-, 192- or 256-bit cipher key into the full AES round-key schedule. The key length is selected at run time.
- Generates one 32-bit schedule word per clock into an internal word store.
- Serves registered 128-bit round-key reads to the cipher datapath once expansion is complete. Sits between the key-load interface and the round controller.

Parameters:
- MAX_KEY_BITS, 256, largest key size supported (128, 192 or 256). Store depth = 4*(MAX_NR+1) words, where MAX_NR = MAX_KEY_BITS/32+6.
- RD_ADDR_W, 4, round-key read address width (must cover 0..MAX_NR).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; latches key and key_len, begins expansion.
- key_len  in  2  00=128, 01=192, 10=256; 11 is illegal and treated as 128.
- original_key  in  MAX_KEY_BITS  cipher key, MSB-aligned; unused LSBs ignored.
- read_addr  in  RD_ADDR_W  round index to read.
- round_key  out  128  registered round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}.
- num_rounds  out  4  Nr for latched key_len (10/12/14).
- busy  out  1  high while expanding.
- generation_done  out  1  high when schedule valid; held until next start or rst.

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, busy=0, generation_done=0, round_key=0, num_rounds=10, word index i=0, rcon=01. The word store is not cleared.
- Derived values: Nk=4/6/8, Nr=Nk+6, total words W=4*(Nr+1)=44/52/60.
- States:
  - IDLE -> LOAD on start.
  - LOAD, 1 cycle: writes w[0..Nk-1] from original_key (w[0] = MSB word), sets i=Nk, rcon=01, busy=1, generation_done=0.
  - EXPAND, one word per cycle: temp = w[i-1].
    - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon), i.e. 01,02,..,80,1B,36.
    - Else if Nk==8 and i mod Nk == 4: temp = SubWord(temp).
    - Write w[i] = w[i-Nk] ^ temp, then i++.
    - Leaves to DONE after writing w[W-1].
  - DONE: busy=0, generation_done=1.
- Latency from start edge to generation_done=1: 1+(W-Nk) cycles = 41 / 47 / 53 for 128 / 192 / 256.
- i mod Nk uses a wrap counter reset at Nk. No divider.
- Reads: round_key updates one cycle after read_addr is sampled, and only while generation_done=1; otherwise it holds its value. read_addr > Nr returns 128'h0.
- start while busy: ignored. The schedule in progress completes unaffected.
- start in DONE: restarts at LOAD. generation_done drops the cycle after start.
- rst mid-expansion: returns to IDLE in the next cycle. The partial schedule is never flagged valid.
- The SubWord S-box is shared with the existing g-function submodule: 4 S-boxes, combinational.

Optional Feature:
- Macro AES_KEY_EQ_INV_EN.
- When defined: adds input read_inv (1 bit).
  - When read_inv=1 and 1 <= read_addr <= Nr-1, round_key returns InvMixColumns of the stored round key (equivalent inverse cipher key).
  - Rounds 0 and Nr are returned unmodified.
  - Same 1-cycle read latency.
- When undefined: the port is absent and no InvMixColumns logic is built. Reads behave as above.

Test Plan:
- 128-bit expansion: key_len=00, key=2b7e1516 28aed2a6 abf71588 09cf4f3c, start. Required:
  - generation_done exactly 41 cycles later.
  - read 1 = a0fafe17 88542cb1 23a33939 2a6c7605.
  - read 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - num_rounds=10.
- 192-bit expansion: key_len=01, key=8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b. Required:
  - done after 47 cycles.
  - read 12 = e98ba06f 448c773c 8ecc7204 01002202.
  - read 13 = 0.
- 256-bit expansion: key_len=10, key=603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4. Required:
  - done after 53 cycles.
  - read 14 = fe4890d1 e6188d0b 046df344 706c631e.
- start pulse at cycle 20 of a 128-bit expansion: ignored. Required: round 10 result and 41-cycle latency unchanged.
- rst asserted at cycle 15, then new 256-bit start: generation_done stays 0 through reset. Required: the fresh schedule matches the 256-bit vector above.
- With AES_KEY_EQ_INV_EN, 128-bit key: read_addr=0 with read_inv=1 returns the original key. read_addr=1 with read_inv=1 returns InvMixColumns(a0fafe17 88542cb1 23a33939 2a6c7605), checked against the model.
